// File: rtl/spike_train_encoder.sv
// Rate-coding spike train encoder.
// For every time step all M pixels are re-read from an external pixel memory.
// Each pixel is compared against a fresh LFSR sample to build one M-bit spike
// vector. The vector is held on ips/valid_ips until the core acknowledges it
// with TU_incre. After T_STEPS acknowledged steps a single done_img pulse
// closes the image.
module spike_train_encoder #(
  parameter int                M       = 784,
  parameter int                PW      = 8,
  parameter int                ADDR_W  = 10,
  parameter int                T_STEPS = 350,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_img,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [PW-1:0]     pix_data,
  input  logic              TU_incre,
  output logic [M-1:0]      ips,
  output logic              valid_ips,
  output logic              busy,
  output logic              done_img,
  output logic [15:0]       ts_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_DRAIN   = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(M - 1);
  localparam logic [PW-1:0]     PIX_MAX   = {PW{1'b1}};
  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400);
  localparam logic [16:0]       T_LAST    = 17'(T_STEPS);

  // One Galois LFSR step: shift right, fold the taps in when a 1 falls out.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    if (cur[0]) begin
      lfsr_next = (cur >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr_next = cur >> 1;
    end
  endfunction

  // Full-scale pixels always fire; others fire when brighter than the random sample.
  function automatic logic spike_of(input logic [PW-1:0] pix, input logic [PW-1:0] rnd);
    if (pix == PIX_MAX) begin
      spike_of = 1'b1;
    end else begin
      spike_of = (pix > rnd);
    end
  endfunction

  state_t              state_q, state_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cap_q, cap_d;
  logic [ADDR_W-1:0]   cap_idx_q, cap_idx_d;
  logic [M-1:0]        shadow_q, shadow_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [M-1:0]        ips_q, ips_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         ts_q, ts_d;

  logic                ack;
  logic                last_step;

  // A step is acknowledged only while a vector is actually being presented.
  assign ack       = (state_q == S_PRESENT) && valid_q && TU_incre;
  assign last_step = (({1'b0, ts_q} + 17'd1) == T_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_img) state_d = S_FILL;
        else           state_d = S_IDLE;
      end
      S_FILL: begin
        if (addr_q == LAST_ADDR) state_d = S_DRAIN;
        else                     state_d = S_FILL;
      end
      S_DRAIN: state_d = S_PRESENT;
      S_PRESENT: begin
        if (ack) begin
          if (last_step) state_d = S_DONE;
          else           state_d = S_FILL;
        end else begin
          state_d = S_PRESENT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values: read sequencing, capture, presentation.
  always_comb begin
    rd_d      = 1'b0;
    addr_d    = addr_q;
    cap_d     = rd_q;
    cap_idx_d = addr_q;
    shadow_d  = shadow_q;
    lfsr_d    = lfsr_q;
    ips_d     = ips_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ts_d      = ts_q;

    // Read data lands one cycle after its strobe; consume one LFSR sample per pixel.
    if (cap_q) begin
      shadow_d[cap_idx_q] = spike_of(pix_data, lfsr_q[PW-1:0]);
      lfsr_d              = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_img) begin
          rd_d   = 1'b1;
          addr_d = {ADDR_W{1'b0}};
          busy_d = 1'b1;
          ts_d   = 16'd0;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_FILL: begin
        if (addr_q != LAST_ADDR) begin
          rd_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
        end else begin
          rd_d = 1'b0;
        end
      end
      S_DRAIN: begin
        rd_d = 1'b0;
      end
      S_PRESENT: begin
        if (!valid_q) begin
          // Shadow is complete (last pixel landed at the end of DRAIN).
          ips_d   = shadow_q;
          valid_d = 1'b1;
        end else if (TU_incre) begin
          valid_d = 1'b0;
          ts_d    = (ts_q == 16'hFFFF) ? ts_q : ts_q + 16'd1;
          if (last_step) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            rd_d   = 1'b1;
            addr_d = {ADDR_W{1'b0}};
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      S_DONE: begin
        done_d = 1'b0;
      end
      default: begin
        rd_d    = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q      <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      cap_q     <= 1'b0;
      cap_idx_q <= {ADDR_W{1'b0}};
      shadow_q  <= {M{1'b0}};
      lfsr_q    <= SEED;
      ips_q     <= {M{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ts_q      <= 16'd0;
    end else begin
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      cap_q     <= cap_d;
      cap_idx_q <= cap_idx_d;
      shadow_q  <= shadow_d;
      lfsr_q    <= lfsr_d;
      ips_q     <= ips_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ts_q      <= ts_d;
    end
  end

  assign pix_rd    = rd_q;
  assign pix_addr  = addr_q;
  assign ips       = ips_q;
  assign valid_ips = valid_q;
  assign busy      = busy_q;
  assign done_img  = done_q;
  assign ts_count  = ts_q;

endmodule

// File: tb/tb_spike_train_encoder.sv
// Self-checking bench for spike_train_encoder.
// Instance A (3 steps) covers protocol, timing and corner cases; instance B
// (350 steps, all pixels 128) covers spike statistics and reproducibility.
module tb_spike_train_encoder;

  localparam int          M    = 16;
  localparam int          AW   = 4;
  localparam int          T_A  = 3;
  localparam int          T_B  = 350;
  localparam int unsigned SEED = 32'h0000ACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          start_a = 1'b0, tu_a = 1'b0, rd_a, valid_a, busy_a, done_a;
  logic [AW-1:0] addr_a;
  logic [7:0]    pd_a = 8'd0;
  logic [M-1:0]  ips_a;
  logic [15:0]   ts_a;

  logic          start_b = 1'b0, tu_b = 1'b0, rd_b, valid_b, busy_b, done_b;
  logic [AW-1:0] addr_b;
  logic [7:0]    pd_b = 8'd0;
  logic [M-1:0]  ips_b;
  logic [15:0]   ts_b;

  logic [7:0]  mem_a [M];
  int          checks = 0;
  int          failures = 0;
  int unsigned model_lfsr_a = SEED;
  int unsigned model_lfsr_b = SEED;

  int            rd_cnt_a = 0, addr_err_a = 0, vrise_a = 0, done_cnt_a = 0;
  logic          prev_rd_a = 1'b0, prev_valid_a = 1'b0;
  logic [AW-1:0] prev_addr_a = '0;

  typedef struct {
    int           mode;       // 0 zeros, 1 full-scale, 2 ramp, 3 random, 4 random with extremes
    int           ack_delay;  // cycles between valid and acknowledge, -1 = random
    int           inj;        // cycle index of a stray start/TU pulse during fill, -1 = none
    bit           has_const;
    logic [M-1:0] constv;
  } vec_t;
  vec_t tbl [5];

  spike_train_encoder #(.M(M), .PW(8), .ADDR_W(AW), .T_STEPS(T_A), .LFSR_W(16), .SEED(16'hACE1)) u_a (
    .clk(clk), .rst(rst), .start_img(start_a), .pix_rd(rd_a), .pix_addr(addr_a),
    .pix_data(pd_a), .TU_incre(tu_a), .ips(ips_a), .valid_ips(valid_a),
    .busy(busy_a), .done_img(done_a), .ts_count(ts_a));

  spike_train_encoder #(.M(M), .PW(8), .ADDR_W(AW), .T_STEPS(T_B), .LFSR_W(16), .SEED(16'hACE1)) u_b (
    .clk(clk), .rst(rst), .start_img(start_b), .pix_rd(rd_b), .pix_addr(addr_b),
    .pix_data(pd_b), .TU_incre(tu_b), .ips(ips_b), .valid_ips(valid_b),
    .busy(busy_b), .done_img(done_b), .ts_count(ts_b));

  always #5 clk = ~clk;

  // Pixel memories: data appears the cycle after the address.
  always @(posedge clk) begin
    pd_a <= mem_a[addr_a];
    pd_b <= (rd_b || !rd_b) ? 8'd128 : 8'd0;
  end

  // Bus monitor for instance A: address contiguity, read count, valid rises, done pulses.
  always @(posedge clk) begin
    prev_rd_a    <= rd_a;
    prev_addr_a  <= addr_a;
    prev_valid_a <= valid_a;
    if (rd_a) rd_cnt_a <= rd_cnt_a + 1;
    if ((rd_a && int'(addr_a) != (prev_rd_a ? int'(prev_addr_a) + 1 : 0)) ||
        (prev_rd_a && !rd_a && int'(prev_addr_a) != M - 1))
      addr_err_a <= addr_err_a + 1;
    if (valid_a && !prev_valid_a) vrise_a <= vrise_a + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned lfsr_step(input int unsigned l);
    if (l % 2 == 1) return (l >> 1) ^ 32'h0000B400;
    return l >> 1;
  endfunction

  // Reference: pixels are visited in address order, each consuming one random sample.
  task automatic model_vec_a(output logic [M-1:0] v);
    int unsigned r;
    v = '0;
    for (int k = 0; k < M; k++) begin
      r    = model_lfsr_a % 256;
      v[k] = (mem_a[k] == 8'd255) || (int'(mem_a[k]) > int'(r));
      model_lfsr_a = lfsr_step(model_lfsr_a);
    end
  endtask

  task automatic model_vec_b(output logic [M-1:0] v);
    int unsigned r;
    v = '0;
    for (int k = 0; k < M; k++) begin
      r    = model_lfsr_b % 256;
      v[k] = (128 > int'(r));
      model_lfsr_b = lfsr_step(model_lfsr_b);
    end
  endtask

  task automatic fill_mem(input int mode);
    for (int k = 0; k < M; k++) begin
      case (mode)
        0:       mem_a[k] = 8'd0;
        1:       mem_a[k] = 8'd255;
        2:       mem_a[k] = 8'(k * 17);
        3:       mem_a[k] = 8'($urandom_range(0, 255));
        default: begin
          case ($urandom_range(0, 2))
            0:       mem_a[k] = 8'd0;
            1:       mem_a[k] = 8'd255;
            default: mem_a[k] = 8'($urandom_range(0, 255));
          endcase
        end
      endcase
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_lfsr_a = SEED;
    model_lfsr_b = SEED;
  endtask

  // Waits (bounded) for valid on A, counting cycles since the last start/ack edge.
  task automatic wait_valid(input int inj, output int lat);
    lat = 0;
    while (!valid_a && lat < 200) begin
      start_a = (lat == inj);
      tu_a    = (lat == inj);
      tick();
      lat++;
    end
    start_a = 1'b0;
    tu_a    = 1'b0;
  endtask

  // Runs steps first..T_A-1 of an image already started on A; ends in the DONE cycle.
  task automatic run_steps(input int first, input int ack_delay, input int inj,
                           input bit has_const, input logic [M-1:0] constv, input string tag);
    logic [M-1:0] ev;
    int lat, rd0, dly, hold_bad;
    for (int s = first; s < T_A; s++) begin
      rd0 = rd_cnt_a;
      wait_valid(inj, lat);
      model_vec_a(ev);
      check({tag, "_latency"}, lat, M + 2);
      check({tag, "_ips"}, longint'(ips_a), longint'(ev));
      if (has_const) check({tag, "_ips_const"}, longint'(ips_a), longint'(constv));
      check({tag, "_rd_count"}, rd_cnt_a - rd0, M);
      check({tag, "_ts_hold"}, longint'(ts_a), s);
      dly = (ack_delay < 0) ? int'($urandom_range(0, 4)) : ack_delay;
      hold_bad = 0;
      for (int d = 0; d < dly; d++) begin
        tick();
        if (valid_a !== 1'b1 || ips_a !== ev) hold_bad++;
      end
      check({tag, "_hold"}, hold_bad, 0);
      tu_a = 1'b1;
      tick();
      tu_a = 1'b0;
      check({tag, "_valid_drop"}, longint'(valid_a), 0);
      check({tag, "_ts"}, longint'(ts_a), s + 1);
      check({tag, "_done"}, longint'(done_a), (s == T_A - 1) ? 1 : 0);
      check({tag, "_busy"}, longint'(busy_a), (s == T_A - 1) ? 0 : 1);
    end
  endtask

  task automatic run_long(input string tag);
    logic [M-1:0] ev;
    int bad, total, lat;
    bad = 0;
    total = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int s = 0; s < T_B; s++) begin
      lat = 0;
      while (!valid_b && lat < 100) begin
        tick();
        lat++;
      end
      model_vec_b(ev);
      if (ips_b !== ev || lat != M + 2) bad++;
      total += $countones(ips_b);
      tu_b = 1'b1;
      tick();
      tu_b = 1'b0;
    end
    check({tag, "_bad_steps"}, bad, 0);
    check({tag, "_rate_in_50pct_pm3"}, (total >= 2632 && total <= 2968) ? 1 : 0, 1);
    check({tag, "_ts"}, longint'(ts_b), T_B);
    check({tag, "_done"}, longint'(done_b), 1);
    tick();
    check({tag, "_done_clear"}, longint'(done_b), 0);
  endtask

  initial begin
    int v0, d0, ae0, rd0, lat, bad, ts0;
    logic [M-1:0] ev;

    tbl[0] = '{0,  2, -1, 1'b1, 16'h0000};
    tbl[1] = '{1,  2, -1, 1'b1, 16'hFFFF};
    tbl[2] = '{2,  1, -1, 1'b0, 16'h0000};
    tbl[3] = '{3, -1, -1, 1'b0, 16'h0000};
    tbl[4] = '{4, -1,  7, 1'b0, 16'h0000};
    fill_mem(0);

    // Power-on reset: outputs cleared asynchronously, before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_ips",   longint'(ips_a),   0);
    check("rst_valid", longint'(valid_a), 0);
    check("rst_rd",    longint'(rd_a),    0);
    check("rst_addr",  longint'(addr_a),  0);
    check("rst_busy",  longint'(busy_a),  0);
    check("rst_done",  longint'(done_a),  0);
    check("rst_ts",    longint'(ts_a),    0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Table-driven images.
    for (int i = 0; i < 5; i++) begin
      fill_mem(tbl[i].mode);
      v0 = vrise_a; d0 = done_cnt_a; ae0 = addr_err_a;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("img_busy_rise", longint'(busy_a), 1);
      check("img_ts_clear",  longint'(ts_a),   0);
      run_steps(0, tbl[i].ack_delay, tbl[i].inj, tbl[i].has_const, tbl[i].constv, $sformatf("tbl%0d", i));
      tick();
      check("img_done_single", longint'(done_a), 0);
      check("img_valid_count", vrise_a - v0, T_A);
      check("img_done_count",  done_cnt_a - d0, 1);
      check("img_addr_contig", addr_err_a - ae0, 0);
    end

    // Long stall in PRESENT: nothing moves until TU_incre.
    fill_mem(3);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_valid(-1, lat);
    model_vec_a(ev);
    check("stall_ips", longint'(ips_a), longint'(ev));
    rd0 = rd_cnt_a;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (valid_a !== 1'b1 || ips_a !== ev || ts_a !== 16'd0) bad++;
    end
    check("stall_stable", bad, 0);
    check("stall_no_rd", rd_cnt_a - rd0, 0);
    tu_a = 1'b1;
    tick();
    tu_a = 1'b0;
    check("stall_ack_ts", longint'(ts_a), 1);
    check("stall_ack_valid", longint'(valid_a), 0);
    run_steps(1, 0, -1, 1'b0, '0, "stall");
    tick();

    // Stray start/TU during fill, start in DONE ignored, start one cycle later accepted.
    fill_mem(4);
    ae0 = addr_err_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    run_steps(0, 1, 5, 1'b0, '0, "midfill");
    ts0 = T_A;
    start_a = 1'b1;
    tick();
    check("done_start_ignored_busy", longint'(busy_a), 0);
    check("done_start_ignored_ts",   longint'(ts_a),   ts0);
    tick();
    start_a = 1'b0;
    check("after_done_start_busy", longint'(busy_a), 1);
    check("after_done_start_ts",   longint'(ts_a),   0);
    run_steps(0, 0, -1, 1'b0, '0, "restart");
    tick();
    check("midfill_addr_contig", addr_err_a - ae0, 0);

    // Statistics and reproducibility on instance B, reseeded by reset each run.
    do_reset();
    run_long("long_run1");
    do_reset();
    run_long("long_run2");

    // Reset in PRESENT: async clear, no done, same first vector as after power-on.
    fill_mem(3);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_valid(-1, lat);
    model_vec_a(ev);
    check("pre_rst_ips", longint'(ips_a), longint'(ev));
    d0 = done_cnt_a;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ips",   longint'(ips_a),   0);
    check("mid_rst_valid", longint'(valid_a), 0);
    check("mid_rst_busy",  longint'(busy_a),  0);
    check("mid_rst_ts",    longint'(ts_a),    0);
    check("mid_rst_rd",    longint'(rd_a),    0);
    check("mid_rst_addr",  longint'(addr_a),  0);
    tick();
    tick();
    rst = 1'b0;
    model_lfsr_a = SEED;
    model_lfsr_b = SEED;
    tick();
    check("mid_rst_no_done", done_cnt_a - d0, 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    run_steps(0, 0, -1, 1'b0, '0, "post_rst");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
